// File: rtl/mr_scoreboard_if.sv
// Bundle of ID/ALU/writeback signals between the pipeline control and the
// register scoreboard; master drives requests, slave answers with hazard status.
interface mr_scoreboard_if #(
   parameter int REGSEL_BITS = 5,
   parameter int CNT_BITS    = 2
);
   logic                            id_valid;
   logic [REGSEL_BITS-1:0]          id_rs1;
   logic                            id_rs1_used;
   logic [REGSEL_BITS-1:0]          id_rs2;
   logic                            id_rs2_used;
   logic [REGSEL_BITS-1:0]          id_rd;
   logic                            id_rd_used;
   logic                            alu_ready;
   logic                            wb_valid;
   logic [REGSEL_BITS-1:0]          wb_reg;
   logic                            flush;
   logic                            stall_o;
   logic                            issue_o;
   logic [REGSEL_BITS+CNT_BITS-1:0] inflight_o;
   logic                            busy_o;
   logic                            err_o;

   modport master (
      output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
             id_rd, id_rd_used, alu_ready, wb_valid, wb_reg, flush,
      input  stall_o, issue_o, inflight_o, busy_o, err_o
   );

   modport slave (
      input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
             id_rd, id_rd_used, alu_ready, wb_valid, wb_reg, flush,
      output stall_o, issue_o, inflight_o, busy_o, err_o
   );
endinterface

// File: rtl/mr_scoreboard.sv
// Multi-pending register scoreboard: per-register counters of outstanding
// writes gate ID->ALU issue on RAW hazards and counter saturation.
module mr_scoreboard #(
   parameter int REGSEL_BITS = 5,
   parameter int CNT_BITS    = 2
) (
   input  logic          clk,
   input  logic          rst,
   mr_scoreboard_if.slave sb
);
   localparam int NREGS = 1 << REGSEL_BITS;
   localparam int IW    = REGSEL_BITS + CNT_BITS;
   localparam logic [CNT_BITS-1:0] MAX = '1;

   logic [CNT_BITS-1:0] cnt_q  [1:NREGS-1];
   logic [CNT_BITS-1:0] cnt_rd [NREGS];
   logic [IW-1:0]       inflight_q;
   logic                err_q;

   logic hazard;
   logic issue;
   logic wb_nonzero;
   logic counted_issue;
   logic counted_retire;
   logic underflow;

   // Register 0 is hardwired to zero pending writes so x0 never stalls.
   always_comb begin
      cnt_rd[0] = '0;
      for (int r = 1; r < NREGS; r++) begin
         cnt_rd[r] = cnt_q[r];
      end
   end

   always_comb begin
      hazard = sb.id_valid &&
               ((sb.id_rs1_used && (cnt_rd[sb.id_rs1] != '0)) ||
                (sb.id_rs2_used && (cnt_rd[sb.id_rs2] != '0)) ||
                (sb.id_rd_used  && (cnt_rd[sb.id_rd]  == MAX)));
      issue          = sb.id_valid && sb.alu_ready && !hazard && !sb.flush;
      counted_issue  = issue && sb.id_rd_used && (sb.id_rd != '0);
      wb_nonzero     = sb.wb_valid && (sb.wb_reg != '0);
      counted_retire = wb_nonzero && (cnt_rd[sb.wb_reg] != '0) && !sb.flush;
      underflow      = wb_nonzero && (cnt_rd[sb.wb_reg] == '0) && !sb.flush;
   end

   // An issue and retire landing on the same register cancel each other.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 1; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else if (sb.flush) begin
         for (int r = 1; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (counted_issue && (sb.id_rd == REGSEL_BITS'(r)) &&
                !(counted_retire && (sb.wb_reg == REGSEL_BITS'(r)))) begin
               cnt_q[r] <= cnt_q[r] + 1'b1;
            end else if (counted_retire && (sb.wb_reg == REGSEL_BITS'(r)) &&
                         !(counted_issue && (sb.id_rd == REGSEL_BITS'(r)))) begin
               cnt_q[r] <= cnt_q[r] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= '0;
      end else if (sb.flush) begin
         inflight_q <= '0;
      end else begin
         case ({counted_issue, counted_retire})
            2'b10:   inflight_q <= inflight_q + 1'b1;
            2'b01:   inflight_q <= inflight_q - 1'b1;
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   // Retiring a register with nothing pending is a pipeline bug; remember it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (underflow) begin
         err_q <= 1'b1;
      end
   end

   assign sb.stall_o    = hazard;
   assign sb.issue_o    = issue;
   assign sb.inflight_o = inflight_q;
   assign sb.busy_o     = (inflight_q != '0);
   assign sb.err_o      = err_q;
endmodule

// File: tb/tb_mr_scoreboard.sv
// Directed-vector bench for mr_scoreboard: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_mr_scoreboard;
   localparam int REGSEL_BITS = 5;
   localparam int CNT_BITS    = 2;
   localparam int IW          = REGSEL_BITS + CNT_BITS;

   typedef struct {
      string         name;
      logic          stall;
      logic          issue;
      logic [IW-1:0] inflight;
      logic          err;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t exp_q[$];

   mr_scoreboard_if #(.REGSEL_BITS(REGSEL_BITS), .CNT_BITS(CNT_BITS)) sb_if ();

   mr_scoreboard #(.REGSEL_BITS(REGSEL_BITS), .CNT_BITS(CNT_BITS)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input string field,
                              input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s.%s actual=%0d expected=%0d", name, field, actual, expected);
      end
   endtask

   // One vector per cycle: drive just after the rising edge, queue expectations.
   task automatic applyStimulus(
      input string name, input logic r,
      input logic v, input int rs1, input logic rs1u, input int rs2, input logic rs2u,
      input int rd, input logic rdu, input logic rdy,
      input logic wbv, input int wbr, input logic fl,
      input logic e_stall, input logic e_issue, input int e_infl, input logic e_err);
      exp_t e;
      @(posedge clk);
      #1;
      rst               = r;
      sb_if.id_valid    = v;
      sb_if.id_rs1      = REGSEL_BITS'(rs1);
      sb_if.id_rs1_used = rs1u;
      sb_if.id_rs2      = REGSEL_BITS'(rs2);
      sb_if.id_rs2_used = rs2u;
      sb_if.id_rd       = REGSEL_BITS'(rd);
      sb_if.id_rd_used  = rdu;
      sb_if.alu_ready   = rdy;
      sb_if.wb_valid    = wbv;
      sb_if.wb_reg      = REGSEL_BITS'(wbr);
      sb_if.flush       = fl;
      e.name     = name;
      e.stall    = e_stall;
      e.issue    = e_issue;
      e.inflight = IW'(e_infl);
      e.err      = e_err;
      exp_q.push_back(e);
   endtask

   // Monitor: compare whatever the DUT presents mid-cycle against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.name, "stall_o",    32'(sb_if.stall_o),    32'(e.stall));
            checkOutput(e.name, "issue_o",    32'(sb_if.issue_o),    32'(e.issue));
            checkOutput(e.name, "inflight_o", 32'(sb_if.inflight_o), 32'(e.inflight));
            checkOutput(e.name, "busy_o",     32'(sb_if.busy_o),     32'(e.inflight != '0));
            checkOutput(e.name, "err_o",      32'(sb_if.err_o),      32'(e.err));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      sb_if.id_valid = 1'b0; sb_if.id_rs1 = '0; sb_if.id_rs1_used = 1'b0;
      sb_if.id_rs2 = '0; sb_if.id_rs2_used = 1'b0; sb_if.id_rd = '0;
      sb_if.id_rd_used = 1'b0; sb_if.alu_ready = 1'b0; sb_if.wb_valid = 1'b0;
      sb_if.wb_reg = '0; sb_if.flush = 1'b0;

      //            name           rst v  rs1 u  rs2 u  rd u  rdy wbv wbr fl   stall iss infl err
      applyStimulus("reset",        1, 1, 5, 1, 0, 0, 5, 1, 1,  0, 0, 0,   0, 1, 0, 0);
      applyStimulus("raw_issue",    0, 1, 0, 0, 0, 0, 5, 1, 1,  0, 0, 0,   0, 1, 0, 0);
      applyStimulus("raw_stall",    0, 1, 5, 1, 0, 0, 6, 1, 1,  1, 5, 0,   1, 0, 1, 0);
      applyStimulus("raw_release",  0, 1, 5, 1, 0, 0, 6, 0, 1,  0, 0, 0,   0, 1, 0, 0);
      applyStimulus("sat_issue1",   0, 1, 0, 0, 0, 0, 7, 1, 1,  0, 0, 0,   0, 1, 0, 0);
      applyStimulus("sat_issue2",   0, 1, 0, 0, 0, 0, 7, 1, 1,  0, 0, 0,   0, 1, 1, 0);
      applyStimulus("sat_issue3",   0, 1, 0, 0, 0, 0, 7, 1, 1,  0, 0, 0,   0, 1, 2, 0);
      applyStimulus("sat_stall",    0, 1, 0, 0, 0, 0, 7, 1, 1,  0, 0, 0,   1, 0, 3, 0);
      applyStimulus("sat_retire",   0, 1, 0, 0, 0, 0, 7, 1, 1,  1, 7, 0,   1, 0, 3, 0);
      applyStimulus("sat_release",  0, 1, 0, 0, 0, 0, 7, 1, 1,  0, 0, 0,   0, 1, 2, 0);
      applyStimulus("alu_hold",     0, 1, 1, 1, 0, 0, 2, 1, 0,  0, 0, 0,   0, 0, 3, 0);
      applyStimulus("sim_setup",    0, 1, 0, 0, 0, 0, 3, 1, 1,  0, 0, 0,   0, 1, 3, 0);
      applyStimulus("sim_both",     0, 1, 0, 0, 0, 0, 3, 1, 1,  1, 3, 0,   0, 1, 4, 0);
      applyStimulus("sim_check",    0, 1, 3, 1, 0, 0, 0, 0, 1,  1, 3, 0,   1, 0, 4, 0);
      applyStimulus("sim_after",    0, 1, 3, 1, 0, 0, 0, 0, 1,  0, 0, 0,   0, 1, 3, 0);
      applyStimulus("x0_issue",     0, 1, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0,   0, 1, 3, 0);
      applyStimulus("x0_read",      0, 1, 0, 1, 0, 1, 0, 0, 1,  1, 0, 0,   0, 1, 3, 0);
      applyStimulus("x0_noerr",     0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,   0, 0, 3, 0);
      applyStimulus("uf_wb9",       0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 9, 0,   0, 0, 3, 0);
      applyStimulus("uf_sticky",    0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,   0, 0, 3, 1);
      applyStimulus("uf_sticky2",   0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,   0, 0, 3, 1);
      applyStimulus("flush_issue",  0, 1, 0, 0, 0, 0, 4, 1, 1,  1, 7, 1,   0, 0, 3, 1);
      applyStimulus("flush_after",  0, 1, 7, 1, 0, 0, 7, 1, 1,  0, 0, 0,   0, 1, 0, 1);
      applyStimulus("pre_rst",      0, 1, 0, 0, 0, 0, 8, 1, 1,  0, 0, 0,   0, 1, 1, 1);
      applyStimulus("async_rst",    1, 1, 8, 1, 0, 0, 0, 0, 1,  0, 0, 0,   0, 1, 0, 0);
      applyStimulus("rst_release",  0, 1, 8, 1, 0, 0, 8, 1, 1,  0, 0, 0,   0, 1, 0, 0);
      applyStimulus("post_rst",     0, 1, 0, 0, 8, 1, 0, 0, 1,  0, 0, 0,   1, 0, 1, 0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(posedge clk);
      end
      @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain actual=%0d pending expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mr_scoreboard.md
MR_SCOREBOARD -- requirements
Module: mr_scoreboard

Interface
REQ-001 SHALL have parameter REGSEL_BITS, default 5, register-select width (2^REGSEL_BITS architectural registers).
REQ-002 SHALL have parameter CNT_BITS, default 2, width of each per-register pending counter (max MAX=2^CNT_BITS-1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port id_valid  input  1  ID presents a decoded instruction.
REQ-006 SHALL have port id_rs1  input  REGSEL_BITS  source register 1.
REQ-007 SHALL have port id_rs1_used  input  1  instruction reads rs1.
REQ-008 SHALL have port id_rs2  input  REGSEL_BITS  source register 2.
REQ-009 SHALL have port id_rs2_used  input  1  instruction reads rs2.
REQ-010 SHALL have port id_rd  input  REGSEL_BITS  destination register.
REQ-011 SHALL have port id_rd_used  input  1  instruction writes rd.
REQ-012 SHALL have port alu_ready  input  1  ALU accepts an instruction this cycle.
REQ-013 SHALL have port wb_valid  input  1  writeback retires a register write.
REQ-014 SHALL have port wb_reg  input  REGSEL_BITS  register being written back.
REQ-015 SHALL have port flush  input  1  discard all pending writes.
REQ-016 SHALL have port stall_o  output  1  hazard; ID must hold.
REQ-017 SHALL have port issue_o  output  1  instruction transfers ID->ALU this cycle.
REQ-018 SHALL have port inflight_o  output  REGSEL_BITS+CNT_BITS  total outstanding writes.
REQ-019 SHALL have port busy_o  output  1  inflight_o != 0.
REQ-020 SHALL have port err_o  output  1  sticky retire-underflow flag.

Function
REQ-021 SHALL keep counter cnt[r] per register r=1..2^REGSEL_BITS-1; cnt[0] SHALL read constant 0 and never change.
REQ-022 SHALL compute hazard combinationally from registered counters only: id_valid & ((rs1_used & cnt[rs1]!=0) | (rs2_used & cnt[rs2]!=0) | (rd_used & cnt[rd]==MAX)).
REQ-023 SHALL drive stall_o = hazard; same-cycle wb_valid SHALL NOT clear a hazard (visible next cycle).
REQ-024 SHALL drive issue_o = id_valid & alu_ready & !hazard & !flush.
REQ-025 Counted issue = issue_o & id_rd_used & id_rd!=0; SHALL increment cnt[id_rd] at the next edge.
REQ-026 Counted retire = wb_valid & wb_reg!=0 & cnt[wb_reg]!=0 & !flush; SHALL decrement cnt[wb_reg] at the next edge.
REQ-027 Counted issue and counted retire to the same register in one cycle SHALL leave that counter unchanged.
REQ-028 wb_valid to a nonzero register with cnt==0 and flush low SHALL leave counters unchanged and set err_o at the next edge; err_o SHALL stay 1 until reset.
REQ-029 wb_valid to register 0 SHALL have no effect and SHALL NOT set err_o.
REQ-030 inflight_o SHALL be a register: +1 per counted issue, -1 per counted retire, unchanged when both occur; it SHALL always equal the sum of cnt[].
REQ-031 busy_o SHALL be combinational from inflight_o.
REQ-032 flush SHALL clear all cnt[] and inflight_o at the next edge, override any same-cycle issue or retire, and not set err_o.
REQ-033 Counters SHALL never wrap: REQ-022 guarantees no increment at MAX; REQ-026 guarantees no decrement at 0.
REQ-034 Counter updates SHALL take effect one cycle after the triggering edge; no other latency.

Reset
REQ-035 On rst assertion, all cnt[], inflight_o and err_o SHALL go to 0 immediately, independent of clk.
REQ-036 During and after reset, busy_o=0; stall_o=0 for any input; issue_o = id_valid & alu_ready & !flush.
REQ-037 Reset mid-operation SHALL discard all pending state; the first edge after deassertion SHALL update from zero counters.

Verification
REQ-038 RAW: issue rd=5; next cycle id_valid, rs1=5 -> stall_o=1, issue_o=0; wb_valid wb_reg=5 -> stall_o=0 the following cycle, inflight_o 1->0.
REQ-039 Saturation (CNT_BITS=2): three issues with rd=7, no wb -> cnt[7]=3; fourth instruction with rd=7 -> stall_o=1; one retire of 7 -> fourth issues next cycle.
REQ-040 Simultaneous: cnt[3]=1; same cycle issue rd=3 and wb_reg=3 -> cnt[3] stays 1, inflight_o unchanged.
REQ-041 x0: issue rd=0 then rs1=0 -> no stall, inflight_o=0; wb_reg=0 with cnt 0 -> err_o stays 0.
REQ-042 Underflow/flush: wb_reg=9 with cnt[9]=0 -> err_o=1 and sticky; inflight_o=3 plus flush with concurrent issue -> inflight_o=0, issue_o=0 that cycle.
REQ-043 Async reset: assert rst between edges with inflight_o=2, err_o=1 -> both 0 before the next edge.
